// File: rtl/sevseg_pkg.sv
// sevseg_pkg: shared definitions for the seven-segment scan decoder.
//   - Active-low 7-bit segment constants (bit0..bit6 = a..g)
//   - Decoder state enumeration
//   - Helpers for locating / validating the single low anode bit
package sevseg_pkg;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_A     = 7'h08;
    localparam logic [6:0] SEG_B     = 7'h03;
    localparam logic [6:0] SEG_C     = 7'h46;
    localparam logic [6:0] SEG_D     = 7'h21;
    localparam logic [6:0] SEG_E     = 7'h06;
    localparam logic [6:0] SEG_F     = 7'h0E;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        HOLD   = 2'd2
    } sevseg_dec_state_t;

    // Position of the (lowest) zero bit; only meaningful when exactly one bit is low.
    function automatic logic [2:0] onehot_cold_index(input logic [7:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (!v[i]) begin
                idx = i[2:0];
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    // True when exactly one bit of v is low.
    function automatic logic onehot_cold_valid(input logic [7:0] v);
        int zeros;
        zeros = 0;
        for (int i = 0; i < 8; i++) begin
            if (!v[i]) begin
                zeros = zeros + 1;
            end else begin
                zeros = zeros;
            end
        end
        return (zeros == 1);
    endfunction

endpackage

// File: rtl/sevseg_scan_decoder_pattern_decode.sv
// sevseg_pattern_decode: combinational active-low segment pattern to hex nibble.
// Ports:
//   seg    in  7  segment lines a..g, active-low
//   nibble out 4  decoded hex value (0 when not legal)
//   legal  out 1  pattern is one of the 16 hex glyphs
//   blank  out 1  all segments off
module sevseg_pattern_decode
    import sevseg_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] nibble,
    output logic       legal,
    output logic       blank
);

    // Glyph lookup; anything outside the table is illegal (blank reported separately).
    always_comb begin
        nibble = 4'h0;
        legal  = 1'b1;
        blank  = 1'b0;
        case (seg)
            SEG_0:     nibble = 4'h0;
            SEG_1:     nibble = 4'h1;
            SEG_2:     nibble = 4'h2;
            SEG_3:     nibble = 4'h3;
            SEG_4:     nibble = 4'h4;
            SEG_5:     nibble = 4'h5;
            SEG_6:     nibble = 4'h6;
            SEG_7:     nibble = 4'h7;
            SEG_8:     nibble = 4'h8;
            SEG_9:     nibble = 4'h9;
            SEG_A:     nibble = 4'hA;
            SEG_B:     nibble = 4'hB;
            SEG_C:     nibble = 4'hC;
            SEG_D:     nibble = 4'hD;
            SEG_E:     nibble = 4'hE;
            SEG_F:     nibble = 4'hF;
            SEG_BLANK: begin
                legal = 1'b0;
                blank = 1'b1;
            end
            default:   legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/sevseg_scan_decoder.sv
// sevseg_scan_decoder: passive decoder for a multiplexed seven-segment bus.
// Synchronizes the anode/segment lines, waits for each scan slot to be stable
// for SETTLE_CYCLES cycles, then decodes that slot's glyph into its digit.
// Optional build macro: SEVSEG_DEC_ERRCNT_EN enables the saturating err_count.
// Ports:
//   clk          in  1          system clock
//   rst          in  1          asynchronous active-high reset
//   anode        in  DIGITS     scan anodes, active-low
//   segment      in  8          a..g + dp, active-low
//   digits       out 4*DIGITS   decoded nibbles, digit i at [4i+3:4i]
//   dp           out DIGITS     decoded decimal points, active-high
//   digit_valid  out DIGITS     last sample for that digit was a legal glyph
//   frame_valid  out 1          pulse when every digit has been sampled
//   bad_pattern  out 1          pulse on sampling an illegal, non-blank glyph
//   err_count    out 8          saturating illegal-pattern count (0 if disabled)
module sevseg_scan_decoder
    import sevseg_pkg::*;
#(
    parameter int DIGITS        = 4,
    parameter int SETTLE_CYCLES = 4,
    parameter int SYNC_STAGES   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DIGITS-1:0]     anode,
    input  logic [7:0]            segment,
    output logic [4*DIGITS-1:0]   digits,
    output logic [DIGITS-1:0]     dp,
    output logic [DIGITS-1:0]     digit_valid,
    output logic                  frame_valid,
    output logic                  bad_pattern,
    output logic [7:0]            err_count
);

    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

    logic [DIGITS-1:0]   anode_sync_r [SYNC_STAGES];
    logic [7:0]          seg_sync_r   [SYNC_STAGES];
    logic [DIGITS-1:0]   anode_prev_r;
    logic [7:0]          seg_prev_r;
    sevseg_dec_state_t   state_r;
    logic [CNT_W-1:0]    cnt_r;
    logic [4*DIGITS-1:0] digits_r;
    logic [DIGITS-1:0]   dp_r;
    logic [DIGITS-1:0]   digit_valid_r;
    logic [DIGITS-1:0]   seen_r;
    logic                frame_valid_r;
    logic                bad_pattern_r;

    logic [DIGITS-1:0]   anode_s;
    logic [7:0]          seg_s;
    logic [7:0]          anode_pad_s;
    logic                slot_valid_s;
    logic [2:0]          slot_idx_s;
    logic                changed_s;
    logic                sample_fire_s;
    logic                bad_s;
    logic [DIGITS-1:0]   seen_set_s;
    logic [3:0]          nibble_s;
    logic                legal_s;
    logic                blank_s;

    // Input synchronizer chains for anode and segment lines.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                anode_sync_r[i] <= '0;
                seg_sync_r[i]   <= 8'h00;
            end
        end else begin
            anode_sync_r[0] <= anode;
            seg_sync_r[0]   <= segment;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                anode_sync_r[i] <= anode_sync_r[i-1];
                seg_sync_r[i]   <= seg_sync_r[i-1];
            end
        end
    end

    assign anode_s = anode_sync_r[SYNC_STAGES-1];
    assign seg_s   = seg_sync_r[SYNC_STAGES-1];

    // Slot qualification: unused upper anode positions read as inactive (high).
    always_comb begin
        anode_pad_s               = 8'hFF;
        anode_pad_s[DIGITS-1:0]   = anode_s;
        slot_valid_s              = onehot_cold_valid(anode_pad_s);
        slot_idx_s                = onehot_cold_index(anode_pad_s);
        changed_s                 = (anode_s != anode_prev_r) || (seg_s != seg_prev_r);
        sample_fire_s             = (state_r == SETTLE) && slot_valid_s && !changed_s &&
                                    (cnt_r == CNT_LAST);
        bad_s                     = !legal_s && !blank_s;
        seen_set_s                = seen_r;
        for (int i = 0; i < DIGITS; i++) begin
            if (int'(slot_idx_s) == i) begin
                seen_set_s[i] = 1'b1;
            end else begin
                seen_set_s[i] = seen_r[i];
            end
        end
    end

    sevseg_pattern_decode u_decode (
        .seg    (seg_s[6:0]),
        .nibble (nibble_s),
        .legal  (legal_s),
        .blank  (blank_s)
    );

    // Settle/hold state machine with registered sample outputs and frame tracking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            anode_prev_r  <= '0;
            seg_prev_r    <= 8'h00;
            state_r       <= IDLE;
            cnt_r         <= '0;
            digits_r      <= '0;
            dp_r          <= '0;
            digit_valid_r <= '0;
            seen_r        <= '0;
            frame_valid_r <= 1'b0;
            bad_pattern_r <= 1'b0;
        end else begin
            anode_prev_r  <= anode_s;
            seg_prev_r    <= seg_s;
            frame_valid_r <= 1'b0;
            bad_pattern_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    cnt_r <= '0;
                    if (slot_valid_s) begin
                        state_r <= SETTLE;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                SETTLE: begin
                    if (!slot_valid_s) begin
                        state_r <= IDLE;
                        cnt_r   <= '0;
                    end else if (changed_s) begin
                        cnt_r   <= '0;
                    end else if (sample_fire_s) begin
                        state_r <= HOLD;
                        cnt_r   <= '0;
                        for (int i = 0; i < DIGITS; i++) begin
                            if (int'(slot_idx_s) == i) begin
                                digits_r[4*i +: 4] <= legal_s ? nibble_s : 4'h0;
                                dp_r[i]            <= ~seg_s[7];
                                digit_valid_r[i]   <= legal_s;
                            end
                        end
                        bad_pattern_r <= bad_s;
                        // Completing the frame pulses and starts a fresh seen-mask.
                        if (&seen_set_s) begin
                            frame_valid_r <= 1'b1;
                            seen_r        <= '0;
                        end else begin
                            seen_r        <= seen_set_s;
                        end
                    end else begin
                        cnt_r <= cnt_r + 1'b1;
                    end
                end
                HOLD: begin
                    if (!slot_valid_s) begin
                        state_r <= IDLE;
                    end else if (changed_s) begin
                        state_r <= SETTLE;
                        cnt_r   <= '0;
                    end else begin
                        state_r <= HOLD;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    cnt_r   <= '0;
                end
            endcase
        end
    end

`ifdef SEVSEG_DEC_ERRCNT_EN
    logic [7:0] err_count_r;

    // Saturating count of illegal samples, stepped with each bad_pattern pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_count_r <= 8'd0;
        end else if (sample_fire_s && bad_s && (err_count_r != 8'hFF)) begin
            err_count_r <= err_count_r + 8'd1;
        end else begin
            err_count_r <= err_count_r;
        end
    end

    assign err_count = err_count_r;
`else
    assign err_count = 8'd0;
`endif

    assign digits      = digits_r;
    assign dp          = dp_r;
    assign digit_valid = digit_valid_r;
    assign frame_valid = frame_valid_r;
    assign bad_pattern = bad_pattern_r;

endmodule

// File: tb/tb_sevseg_scan_decoder.sv
module tb_sevseg_scan_decoder;

    localparam int DIGITS        = 4;
    localparam int SETTLE_CYCLES = 4;
    localparam int SYNC_STAGES   = 2;
    localparam int EXP_LAT       = SYNC_STAGES + SETTLE_CYCLES + 1;
`ifdef SEVSEG_DEC_ERRCNT_EN
    localparam logic [7:0] EXP_ERR = 8'd1;
`else
    localparam logic [7:0] EXP_ERR = 8'd0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  anode = 4'hF;
    logic [7:0]  segment = 8'hFF;
    logic [15:0] digits;
    logic [3:0]  dp;
    logic [3:0]  digit_valid;
    logic        frame_valid;
    logic        bad_pattern;
    logic [7:0]  err_count;

    int          tests_run = 0;
    int          fails = 0;
    int          frame_cnt = 0;
    int          bad_cnt = 0;
    logic [15:0] frame_digits = 16'h0000;

    sevseg_scan_decoder #(
        .DIGITS        (DIGITS),
        .SETTLE_CYCLES (SETTLE_CYCLES),
        .SYNC_STAGES   (SYNC_STAGES)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .anode       (anode),
        .segment     (segment),
        .digits      (digits),
        .dp          (dp),
        .digit_valid (digit_valid),
        .frame_valid (frame_valid),
        .bad_pattern (bad_pattern),
        .err_count   (err_count)
    );

    always #5 clk = ~clk;

    // Pulse monitor, sampled on the inactive edge.
    always @(negedge clk) begin
        if (!rst && frame_valid) begin
            frame_cnt    = frame_cnt + 1;
            frame_digits = digits;
        end
        if (!rst && bad_pattern) begin
            bad_cnt = bad_cnt + 1;
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive(input logic [3:0] a, input logic [7:0] s, input int n);
        anode   = a;
        segment = s;
        step(n);
    endtask

    task automatic do_reset();
        anode   = 4'hF;
        segment = 8'hFF;
        rst     = 1'b1;
        step(2);
        rst     = 1'b0;
        step(2);
    endtask

    task automatic test_reset();
        do_reset();
        tests_run++;
        if ({digits, dp, digit_valid} !== 24'h000000) begin
            fails++;
            $display("FAIL reset_data: got %h required 000000", {digits, dp, digit_valid});
        end
        tests_run++;
        if ({frame_valid, bad_pattern, err_count} !== 10'h000) begin
            fails++;
            $display("FAIL reset_flags: got %h required 000", {frame_valid, bad_pattern, err_count});
        end
    endtask

    task automatic test_scan();
        int f0;
        do_reset();
        f0 = frame_cnt;
        drive(4'hE, 8'hC0, 16);
        drive(4'hD, 8'hF9, 16);
        drive(4'hB, 8'h80, 16);
        tests_run++;
        if (frame_cnt - f0 !== 0) begin
            fails++;
            $display("FAIL scan_early_frame: got %0d required 0", frame_cnt - f0);
        end
        drive(4'h7, 8'h88, 16);
        drive(4'hF, 8'hFF, 8);
        tests_run++;
        if (digits !== 16'hA810) begin
            fails++;
            $display("FAIL scan_digits: got %h required a810", digits);
        end
        tests_run++;
        if (digit_valid !== 4'hF || dp !== 4'h0) begin
            fails++;
            $display("FAIL scan_valid_dp: got %h/%h required f/0", digit_valid, dp);
        end
        tests_run++;
        if (frame_cnt - f0 !== 1) begin
            fails++;
            $display("FAIL scan_frames: got %0d required 1", frame_cnt - f0);
        end
        tests_run++;
        if (frame_digits !== 16'hA810) begin
            fails++;
            $display("FAIL scan_frame_digits: got %h required a810", frame_digits);
        end
    endtask

    task automatic test_glitch();
        int f0;
        do_reset();
        f0 = frame_cnt;
        drive(4'hE, 8'hC0, 3);
        drive(4'hD, 8'hF9, 16);
        drive(4'hF, 8'hFF, 4);
        tests_run++;
        if (digits !== 16'h0010 || digit_valid !== 4'h2) begin
            fails++;
            $display("FAIL glitch_digits: got %h/%h required 0010/2", digits, digit_valid);
        end
        tests_run++;
        if (frame_cnt - f0 !== 0) begin
            fails++;
            $display("FAIL glitch_frame: got %0d required 0", frame_cnt - f0);
        end
    endtask

    task automatic test_blank_illegal();
        int b0;
        int f0;
        do_reset();
        b0 = bad_cnt;
        f0 = frame_cnt;
        drive(4'hB, 8'h7F, 16);
        tests_run++;
        if (bad_cnt - b0 !== 0 || digit_valid !== 4'h0) begin
            fails++;
            $display("FAIL blank: got bad=%0d valid=%h required 0/0", bad_cnt - b0, digit_valid);
        end
        drive(4'hB, 8'h55, 16);
        drive(4'hF, 8'hFF, 4);
        tests_run++;
        if (bad_cnt - b0 !== 1) begin
            fails++;
            $display("FAIL illegal_pulses: got %0d required 1", bad_cnt - b0);
        end
        tests_run++;
        if (digit_valid !== 4'h0 || digits !== 16'h0000 || dp !== 4'h4) begin
            fails++;
            $display("FAIL illegal_out: got %h/%h/%h required 0/0000/4", digit_valid, digits, dp);
        end
        tests_run++;
        if (err_count !== EXP_ERR) begin
            fails++;
            $display("FAIL err_count: got %0d required %0d", err_count, EXP_ERR);
        end
        tests_run++;
        if (frame_cnt - f0 !== 0) begin
            fails++;
            $display("FAIL illegal_frame: got %0d required 0", frame_cnt - f0);
        end
    endtask

    task automatic test_dp();
        do_reset();
        drive(4'h7, 8'h40, 16);
        tests_run++;
        if (digits[15:12] !== 4'h0 || dp !== 4'h8 || digit_valid !== 4'h8) begin
            fails++;
            $display("FAIL dp: got %h/%h/%h required 0/8/8", digits[15:12], dp, digit_valid);
        end
    endtask

    // Continues from test_dp: two low anodes must leave all outputs untouched.
    task automatic test_two_low();
        int f0;
        int b0;
        f0 = frame_cnt;
        b0 = bad_cnt;
        drive(4'hC, 8'hC0, 20);
        tests_run++;
        if (digits !== 16'h0000 || dp !== 4'h8 || digit_valid !== 4'h8) begin
            fails++;
            $display("FAIL two_low_out: got %h/%h/%h required 0000/8/8", digits, dp, digit_valid);
        end
        tests_run++;
        if (frame_cnt - f0 !== 0 || bad_cnt - b0 !== 0) begin
            fails++;
            $display("FAIL two_low_pulses: got %0d/%0d required 0/0", frame_cnt - f0, bad_cnt - b0);
        end
    endtask

    task automatic test_back_to_back();
        int f0;
        do_reset();
        f0 = frame_cnt;
        drive(4'hE, 8'hC0, 16);
        drive(4'hE, 8'hF9, 16);
        drive(4'hD, 8'hA4, 16);
        drive(4'hB, 8'hB0, 16);
        tests_run++;
        if (frame_cnt - f0 !== 0 || digits !== 16'h0321) begin
            fails++;
            $display("FAIL resample_partial: got frames=%0d digits=%h required 0/0321", frame_cnt - f0, digits);
        end
        drive(4'h7, 8'h99, 16);
        drive(4'hF, 8'hFF, 4);
        tests_run++;
        if (frame_cnt - f0 !== 1 || frame_digits !== 16'h4321 || digit_valid !== 4'hF) begin
            fails++;
            $display("FAIL resample_frame: got frames=%0d digits=%h valid=%h required 1/4321/f",
                     frame_cnt - f0, frame_digits, digit_valid);
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        do_reset();
        drive(4'hE, 8'hF9, 16);
        drive(4'h7, 8'h88, 4);
        rst = 1'b1;
        step(1);
        tests_run++;
        if ({digits, dp, digit_valid, frame_valid, bad_pattern} !== 26'h0) begin
            fails++;
            $display("FAIL reset_mid_clear: got %h required 0", {digits, dp, digit_valid});
        end
        rst = 1'b0;
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            step(1);
            if (lat == 0 && digit_valid[3] === 1'b1) begin
                lat = k;
            end
        end
        tests_run++;
        if (lat !== EXP_LAT) begin
            fails++;
            $display("FAIL reset_mid_latency: got %0d required %0d", lat, EXP_LAT);
        end
        tests_run++;
        if (digits !== 16'hA000 || digit_valid !== 4'h8) begin
            fails++;
            $display("FAIL reset_mid_digits: got %h/%h required a000/8", digits, digit_valid);
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_glitch();
        test_blank_illegal();
        test_dp();
        test_two_low();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule

// File: doc/sevseg_scan_decoder.md
Name: sevseg_scan_decoder

Overview:
- Passive decoder for the multiplexed seven-segment bus. It is the inverse of the display controller.
- Samples the anode/segment lines (board pins or an internal loopback), waits for each scan slot to settle, and decodes the segment pattern back to a hex nibble per digit.
- Reports a full frame once every digit has been captured.
- Used for on-board self-check of the counter/display path and as a bench monitor.

Parameters:
- DIGITS, 4, number of anode lines scanned (1..8).
- SETTLE_CYCLES, 4, consecutive stable cycles required before a slot is sampled (>=1).
- SYNC_STAGES, 2, input synchronizer depth (>=1).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- anode  in  DIGITS  scan anodes, active-low, exactly one low when a slot is driven.
- segment  in  8  active-low; bit0..bit6 = a..g, bit7 = dp.
- digits  out  4*DIGITS  decoded nibbles; digit i at [4i+3:4i].
- dp  out  DIGITS  decoded decimal points, active-high.
- digit_valid  out  DIGITS  1 = last sample for that digit was a legal hex pattern.
- frame_valid  out  1  one-cycle pulse when all DIGITS slots have been sampled since the last pulse.
- bad_pattern  out  1  one-cycle pulse on sampling an illegal, non-blank pattern.
- err_count  out  8  illegal-pattern count (see Optional Feature).

Behaviour:
- Reset (async assert, release sync to clk): all outputs 0, synchronizers cleared, seen-mask 0, state IDLE.
- Inputs pass SYNC_STAGES flops. Decoding operates only on synchronized values.
- A slot is valid when the synchronized anode has exactly one 0 bit. All-ones, or more than one 0, is invalid.
- State machine:
  - IDLE: anode invalid. On a valid anode -> SETTLE, cnt=0.
  - SETTLE: cnt increments each cycle anode and segment are unchanged from the prior cycle.
    - Any change with a valid anode restarts SETTLE at cnt=0.
    - Anode becomes invalid -> IDLE.
    - cnt==SETTLE_CYCLES-1 with no change -> sample, then HOLD.
  - HOLD: no resample while inputs are unchanged.
    - Anode or segment change with a valid anode -> SETTLE, cnt=0. A changed pattern under the same anode is resampled.
    - Anode becomes invalid -> IDLE.
- Sample: index i = position of the low anode bit. The registered outputs update on the cycle after the sample cycle:
  - digits[i] = decoded nibble, or 0 if not legal.
  - dp[i] = ~segment[7].
  - digit_valid[i] = legal.
  - seen[i] = 1.
- Decode table (segment[6:0], active-low): 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E (hex values).
  - 6=02 and b=03 are distinct patterns.
  - Blank 7F: digit_valid[i]=0, no bad_pattern, counts as seen.
  - Any other pattern: digit_valid[i]=0, bad_pattern pulses in the same cycle as the output update.
- Frame: when seen becomes all-ones, frame_valid pulses in the same cycle as the completing update, and seen clears to 0.
  - A digit resampled before the frame completes overwrites its outputs and does not double-count.
- Latency from stable pins to output update = SYNC_STAGES + SETTLE_CYCLES + 1 cycles.
- Glitches shorter than SETTLE_CYCLES are never sampled.
- Reset mid-slot: the slot is discarded. After reset release, the current slot must fully re-settle before it is sampled.

Optional Feature:
- Macro SEVSEG_DEC_ERRCNT_EN.
- Defined: err_count is an 8-bit counter that increments on each bad_pattern pulse, saturates at 255, and clears on rst.
- Undefined: err_count is tied to 0 and no counter logic is built.

Decomposition:
- Package sevseg_pkg holds:
  - localparam segment constants SEG_0..SEG_F and SEG_BLANK (7-bit, active-low);
  - typedef enum logic[1:0] {IDLE, SETTLE, HOLD} sevseg_dec_state_t;
  - function onehot_cold_index.
- One combinational sub-module, sevseg_pattern_decode: input seg[6:0]; outputs nibble[3:0], legal, blank.
- The state machine, synchronizers, and frame logic remain in the top module.

Test Plan:
- Scan anode E,D,B,7 with segment C0,F9,80,88, 16 cycles each, defaults -> digits=16'hA810, digit_valid=4'hF, exactly one frame_valid, after slot 3 updates.
- Slot anode E with segment C0 held 3 cycles, then anode D -> digit 0 not updated, no frame.
- Slot anode B with segment 7F (blank) then 55 (illegal) under the same anode -> digit_valid[2]=0; bad_pattern pulses once, for 55 only; err_count=1 when SEVSEG_DEC_ERRCNT_EN is defined, else 0.
- Anode 1100 (two low) for 20 cycles -> state stays IDLE, no outputs change.
- Segment 40 with dp bit low (segment=8'h40) on anode 7 -> digits[15:12]=0, dp[3]=1.
- Assert rst mid-SETTLE, release, keep the slot stable -> all outputs 0 after reset; sample occurs SYNC_STAGES+SETTLE_CYCLES+1 cycles after release.
